// File: rtl/bsk_prm_pkg.sv
// Shared definitions for the BSK command-receiver register block:
// register addresses and the complement-protected byte check.
package bsk_prm_pkg;

    typedef enum logic [1:0] {
        ADDR_COMT = 2'b00,
        ADDR_CMD  = 2'b01,
        ADDR_IND  = 2'b10,
        ADDR_ID   = 2'b11
    } reg_addr_t;

    function automatic logic byte_ok(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

    // Upper nibble carries the active-low command; a corrupt byte yields all-inactive.
    function automatic logic [3:0] byte_nib(input logic [7:0] b);
        return byte_ok(b) ? b[7:4] : 4'hF;
    endfunction

endpackage

// File: rtl/bsk_prm.sv
// PRM register block: latches protected host command words onto active-low
// command outputs, drives indication/enable outputs and serves read-back.
module bsk_prm
    import bsk_prm_pkg::*;
#(
    parameter logic [5:0] VERSION  = 6'h24,
    parameter logic [7:0] PASSWORD = 8'hA6,
    parameter logic [3:0] CS       = 4'b0111
) (
    input  logic        iClk,
    input  logic        iRes,
    inout  logic [15:0] bD,
    input  logic        iRd,
    input  logic        iWr,
    input  logic        iBl,
    input  logic        iKEnable,
    input  logic [1:0]  iA,
    input  logic [3:0]  iCS,
    input  logic [15:0] iComT,
    output logic [15:0] oCom,
    output logic [15:0] oComInd,
    output logic        oCS,
    output logic        oEnable
);

    logic        sel;
    logic        rd_act;
    logic        wr_act;
    logic        comt_hold;
    logic [15:0] rd_data;

    logic [7:0]  pending;
    logic [15:0] cmd;
    logic        cmd_valid;
    logic [15:0] ind;
    logic        en;
    logic [15:0] comt_snap;

    assign sel       = (iCS == CS);
    assign rd_act    = sel && !iRd;
    assign wr_act    = sel && !iWr && iRd;
    assign comt_hold = rd_act && (reg_addr_t'(iA) == ADDR_COMT);

    always_ff @(posedge iClk or negedge iRes) begin
        if (!iRes) begin
            pending   <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            ind       <= '0;
            en        <= 1'b0;
        end else if (wr_act) begin
            case (reg_addr_t'(iA))
                ADDR_COMT: pending <= {byte_nib(bD[15:8]), byte_nib(bD[7:0])};
                ADDR_CMD: begin
                    cmd       <= {byte_nib(bD[15:8]), byte_nib(bD[7:0]), pending};
                    cmd_valid <= 1'b1;
                end
                ADDR_IND:  ind <= bD;
                ADDR_ID:   en  <= byte_ok(bD[7:0]) && bD[0];
                default:   ;
            endcase
        end
    end

    // Snapshot is not reset so test inputs stay readable while iRes is low;
    // it freezes for the whole of a reg-00 read so the host sees a stable word.
    always_ff @(posedge iClk) begin
        if (!comt_hold)
            comt_snap <= iComT;
    end

    always_comb begin
        rd_data = '0;
        case (reg_addr_t'(iA))
            ADDR_COMT: rd_data = comt_snap;
            ADDR_CMD:  rd_data = cmd;
            ADDR_IND:  rd_data = ind;
            ADDR_ID:   rd_data = {PASSWORD, VERSION, iKEnable, ~en};
            default:   rd_data = '0;
        endcase
    end

    assign bD      = rd_act ? rd_data : 'z;
    assign oCS     = ~sel;
    assign oCom    = (cmd_valid && iBl && iRes) ? cmd : 16'hFFFF;
    assign oComInd = ~ind;
    assign oEnable = ~(en && iBl && iRes);

endmodule

// File: tb/tb_bsk_prm.sv
// Directed self-checking bench for bsk_prm with hand-computed expectations.
module tb_bsk_prm;

    logic        iClk = 1'b0;
    logic        iRes;
    wire  [15:0] bD;
    logic        iRd;
    logic        iWr;
    logic        iBl;
    logic        iKEnable;
    logic [1:0]  iA;
    logic [3:0]  iCS;
    logic [15:0] iComT;
    logic [15:0] oCom;
    logic [15:0] oComInd;
    logic        oCS;
    logic        oEnable;

    logic        drv;
    logic [15:0] drv_val;
    logic [15:0] rd_val;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    assign bD = drv ? drv_val : 'z;

    always #5 iClk = ~iClk;

    bsk_prm #(
        .VERSION (6'h24),
        .PASSWORD(8'hA6),
        .CS      (4'b0111)
    ) dut (
        .iClk    (iClk),
        .iRes    (iRes),
        .bD      (bD),
        .iRd     (iRd),
        .iWr     (iWr),
        .iBl     (iBl),
        .iKEnable(iKEnable),
        .iA      (iA),
        .iCS     (iCS),
        .iComT   (iComT),
        .oCom    (oCom),
        .oComInd (oComInd),
        .oCS     (oCS),
        .oEnable (oEnable)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge iClk);
        iCS     = 4'b0111;
        iA      = a;
        drv_val = d;
        drv     = 1'b1;
        iWr     = 1'b0;
        @(posedge iClk);
        @(negedge iClk);
        iWr = 1'b1;
        drv = 1'b0;
        iCS = 4'hF;
        #1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        @(negedge iClk);
        iCS = 4'b0111;
        iA  = a;
        iRd = 1'b0;
        #1;
        d = bD;
        @(negedge iClk);
        iRd = 1'b1;
        iCS = 4'hF;
        #1;
    endtask

    initial begin
        iRes = 1'b0; iRd = 1'b1; iWr = 1'b1; iBl = 1'b1; iKEnable = 1'b1;
        iA = 2'b00; iCS = 4'hF; iComT = 16'h1331; drv = 1'b0; drv_val = '0;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iRes = 1'b1;
        #1;
        check("rst_ocom", oCom, 16'hFFFF);
        check("rst_ind", oComInd, 16'hFFFF);
        check("rst_en", {15'd0, oEnable}, 16'd1);

        // chip-select decode
        iCS = 4'b0000; #1; check("ocs_0000", {15'd0, oCS}, 16'd1);
        iCS = 4'b1111; #1; check("ocs_1111", {15'd0, oCS}, 16'd1);
        iCS = 4'b0111; #1; check("ocs_0111", {15'd0, oCS}, 16'd0);
        iCS = 4'b1111; #1; check("ocs_back", {15'd0, oCS}, 16'd1);

        // read map after reset
        bus_read(2'b00, rd_val); check("rd_a00", rd_val, 16'h1331);
        bus_read(2'b01, rd_val); check("rd_a01", rd_val, 16'h0000);
        bus_read(2'b10, rd_val); check("rd_a10", rd_val, 16'h0000);
        bus_read(2'b11, rd_val); check("rd_a11", rd_val, 16'hA693);

        iRes = 1'b0;
        bus_read(2'b00, rd_val); check("rd_rst_a00", rd_val, 16'h1331);
        bus_read(2'b11, rd_val); check("rd_rst_a11", rd_val, 16'hA693);
        iRes = 1'b1;
        iWr = 1'b0;
        bus_read(2'b01, rd_val); check("rd_wr_a01", rd_val, 16'h0000);
        bus_read(2'b11, rd_val); check("rd_wr_a11", rd_val, 16'hA693);
        iWr = 1'b1;

        // inactive chip select must leave the bus to another driver
        @(negedge iClk);
        iCS = 4'hF; iRd = 1'b0; drv_val = 16'h5A5A; drv = 1'b1;
        #1; check("cs_off_bus", bD, 16'h5A5A);
        drv = 1'b0; iRd = 1'b1;

        // iComT snapshot freeze and refresh
        @(negedge iClk);
        iCS = 4'b0111; iA = 2'b00; iRd = 1'b0;
        #1; check("snap_first", bD, 16'h1331);
        iComT = 16'h987F;
        @(posedge iClk);
        @(negedge iClk);
        check("snap_frozen", bD, 16'h1331);
        iCS = 4'hF;
        @(posedge iClk);
        @(negedge iClk);
        iCS = 4'b0111;
        #1; check("snap_cs_new", bD, 16'h987F);
        iComT = 16'h1234;
        @(posedge iClk);
        @(negedge iClk);
        check("snap_frozen2", bD, 16'h987F);
        iA = 2'b01;
        @(posedge iClk);
        @(negedge iClk);
        iA = 2'b00;
        #1; check("snap_a_new", bD, 16'h1234);
        iRd = 1'b1; iCS = 4'hF;

        // command path
        bus_write(2'b00, 16'hA55A); check("cmd_pend_only", oCom, 16'hFFFF);
        bus_write(2'b01, 16'hF078); check("cmd_commit", oCom, 16'hF7A5);
        iBl = 1'b0; #1; check("cmd_blocked", oCom, 16'hFFFF);
        iBl = 1'b1; #1; check("cmd_unblock", oCom, 16'hF7A5);
        iRes = 1'b0; #1; check("cmd_in_rst", oCom, 16'hFFFF);
        iRes = 1'b1; #1; check("cmd_after_rst", oCom, 16'hFFFF);

        bus_write(2'b00, 16'hA5C3);
        bus_write(2'b01, 16'h8769);
        bus_read(2'b01, rd_val); check("cmd_readback", rd_val, 16'h86AC);
        check("cmd_out", oCom, 16'h86AC);

        // corrupt bytes decode to inactive nibbles
        bus_write(2'b00, 16'h1234);
        bus_write(2'b01, 16'hF078);
        check("cmd_invalid", oCom, 16'hF7FF);

        // writes ignored while held in reset
        iRes = 1'b0;
        bus_write(2'b10, 16'hFFFF);
        iRes = 1'b1;
        bus_read(2'b10, rd_val); check("wr_in_rst", rd_val, 16'h0000);

        // indication
        bus_write(2'b10, 16'h9231); check("ind_out", oComInd, 16'h6DCE);
        iCS = 4'hF; #1; check("ind_cs_off", oComInd, 16'h6DCE);
        iBl = 1'b0; #1; check("ind_blk", oComInd, 16'h6DCE);
        iBl = 1'b1;
        bus_read(2'b10, rd_val); check("ind_read", rd_val, 16'h9231);
        iRes = 1'b0; #1; check("ind_rst", oComInd, 16'hFFFF);
        iRes = 1'b1;

        // terminal enable
        bus_write(2'b11, 16'h00E1); check("en_on", {15'd0, oEnable}, 16'd0);
        bus_read(2'b11, rd_val); check("en_read", rd_val, 16'hA692);
        iBl = 1'b0; #1; check("en_blk", {15'd0, oEnable}, 16'd1);
        iBl = 1'b1; #1; check("en_unblk", {15'd0, oEnable}, 16'd0);
        bus_write(2'b11, 16'h0011); check("en_bad", {15'd0, oEnable}, 16'd1);
        bus_read(2'b11, rd_val); check("en_bad_read", rd_val, 16'hA693);
        iKEnable = 1'b0;
        bus_read(2'b11, rd_val); check("kenable_read", rd_val, 16'hA691);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bsk_prm.md
Name: bsk_prm

Overview:
- Command-receiver register block ("PRM") of the BSK board, sitting on a 16-bit asynchronous-style host bus (iRd/iWr/iCS/iA).
- Latches host-written command words (nibble/complement protected) onto active-low command outputs.
- Provides a command-indication output, a terminal-enable output, and read-back of test inputs, command state and a version/password word.

Parameters:
- VERSION, 6'h24, firmware version, returned in register 11.
- PASSWORD, 8'hA6, board signature, returned in register 11.
- CS, 4'b0111, chip-select code matched against iCS.

Ports:
- iClk  in  1  system clock; all state updates on its rising edge.
- iRes  in  1  reset, asynchronous, active-low.
- bD  inout  16  bidirectional data bus.
- iRd  in  1  read strobe, active-low.
- iWr  in  1  write strobe, active-low.
- iBl  in  1  block, active-low; 0 forces oCom and oEnable inactive.
- iKEnable  in  1  terminal-key status, reported in register 11 bit1.
- iA  in  2  register address.
- iCS  in  4  chip-select code.
- iComT  in  16  command test inputs, read via register 00.
- oCom  out  16  command outputs, active-low.
- oComInd  out  16  command indication outputs, active-low.
- oCS  out  1  0 when iCS==CS, else 1 (combinational).
- oEnable  out  1  terminal enable, active-low.

Behaviour:
- sel = (iCS==CS).
- bD is driven only while sel && iRd==0; otherwise Z. The read mux is combinational from registered state.
- Reads ignore iWr and iRes.
- Write: on an iClk edge with sel && iWr==0 && iRd==1, register iA loads bD. This is level-active, so repeated edges rewrite the same value. Writes are suppressed while iRd==0 (read has priority).
- Byte check: a byte b is valid iff b[7:4] == ~b[3:0]. Its command nibble is b[7:4] (active-low form). An invalid byte yields nibble 4'hF.
- Reg 00:
  - Write: stores the two checked nibbles of bD into pending[7:0]; outputs are unchanged.
  - Read: returns snapshot of iComT. The snapshot loads iComT every edge while no reg-00 read access (sel && !iRd && iA==00) is active, and freezes during such an access.
  - A new access (change of CS, Rd or A) shows the fresh value.
- Reg 01:
  - Write commits cmd <= {nib(bD[15:8]), nib(bD[7:0]), pending} and sets cmd_valid.
  - Read returns cmd raw; reset value 16'h0000.
- Reg 10:
  - Write sets ind <= bD.
  - Read returns ind.
  - oComInd = ~ind; reset ind=0, so oComInd=FFFF.
  - iBl has no effect on oComInd.
- Reg 11:
  - Write sets en <= (valid(bD[7:0]) && bD[0]); an invalid byte clears en.
  - Read returns {PASSWORD, VERSION, iKEnable, ~en}.
- oCom = (cmd_valid && iBl && iRes) ? cmd : 16'hFFFF.
- oEnable = ~(en && iBl && iRes).
- iBl only gates outputs; stored state is kept.
- Reset (iRes=0, asynchronous): pending=0, cmd=0, cmd_valid=0, ind=0, en=0. All writes are ignored while in reset; reads stay functional.

Decomposition:
- Package bsk_prm_pkg holds:
  - address constants ADDR_COMT=2'b00, ADDR_CMD=2'b01, ADDR_IND=2'b10, ADDR_ID=2'b11;
  - function byte_nib(b) returning the checked nibble or 4'hF.
- No sub-module required; the byte check is a package function.

Test Plan:
- oCS decode: iCS=0000 -> 1; 1111 -> 1; 0111 -> 0; back to 1111 -> 1.
- Read map after reset, iComT=1331, iKEnable=1:
  - A00 -> 1331; A01 -> 0000; A10 -> 0000; A11 -> A693.
  - Unchanged with iRes=0 or iWr=0.
  - CS inactive -> bD=Z.
- iComT snapshot:
  - During A00 read, change iComT to 987F -> still 1331.
  - Toggle CS (or Rd, or A 00->01->00) -> 987F.
- Commands, iBl=1:
  - Write A00=A55A -> oCom FFFF.
  - Write A01=F078 -> oCom F7A5.
  - iBl=0 -> FFFF; iRes=0 -> FFFF.
- Commands readback: write A00=A5C3, then A01=8769, then read A01 -> 86AC.
- Indication and enable:
  - Write A10=9231 -> oComInd 6DCE, kept with CS inactive; reset -> FFFF.
  - Write A11=E1 -> oEnable 0 and read A692; iBl=0 -> oEnable 1.
  - Write A11=11 -> read A693 (enable cleared).
